// File: rtl/poly_commutator.sv
// Polyphase input commutator: offset-binary samples -> two's complement, PHASES per frame, optional COMMUTATOR_DROP_CNT_EN drop counter.
// Latency: completing strobe in cycle n presents frame_valid/frame_data in cycle n+1.
// Backpressure: fill never stalls; a frame completing while the holding register is full and not handshaking is dropped (overrun).
module poly_commutator #(
    parameter int DATA_WIDTH = 8,
    parameter int PHASES     = 4,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_change,
    output logic [PHASES*DATA_WIDTH-1:0] frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [CNT_WIDTH-1:0]         phase_idx,
    output logic                         overrun,
`ifdef COMMUTATOR_DROP_CNT_EN
    output logic [7:0]                   drop_cnt,
`endif
    input  logic                         overrun_clr
);

    localparam logic [CNT_WIDTH-1:0] LAST_PHASE = CNT_WIDTH'(PHASES - 1);

    logic [DATA_WIDTH-1:0]        sample_cvt;
    logic [PHASES*DATA_WIDTH-1:0] collect;
    logic [PHASES*DATA_WIDTH-1:0] full_frame;
    logic                         complete;
    logic                         handshake;
    logic                         load;
    logic                         drop;

    assign sample_cvt = {~data_in[DATA_WIDTH-1], data_in[DATA_WIDTH-2:0]};
    assign complete   = data_change && (phase_idx == LAST_PHASE);
    assign handshake  = frame_valid && frame_ready;
    // The completing sample always lands in the top slot, so splice it in directly.
    assign full_frame = {sample_cvt, collect[(PHASES-1)*DATA_WIDTH-1:0]};
    assign load       = complete && (!frame_valid || frame_ready);
    assign drop       = complete && frame_valid && !frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collect   <= '0;
            phase_idx <= '0;
        end else if (data_change) begin
            for (int k = 0; k < PHASES; k++) begin
                if (phase_idx == CNT_WIDTH'(k))
                    collect[k*DATA_WIDTH +: DATA_WIDTH] <= sample_cvt;
            end
            phase_idx <= phase_idx + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
        end else if (load) begin
            frame_data  <= full_frame;
            frame_valid <= 1'b1;
        end else if (handshake) begin
            frame_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (overrun_clr)
            overrun <= 1'b0;
    end

`ifdef COMMUTATOR_DROP_CNT_EN
    // A clear coinciding with a drop restarts the count at one, not zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (overrun_clr)
            drop_cnt <= drop ? 8'd1 : 8'd0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_poly_commutator.sv
// Directed self-checking bench for poly_commutator (PHASES=4; PHASES=2 saturation instance when COMMUTATOR_DROP_CNT_EN is defined).
module tb_poly_commutator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_change = 1'b0;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [1:0]  phase_idx;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef COMMUTATOR_DROP_CNT_EN
    logic [7:0]  drop_cnt;
    logic [7:0]  d2_data_in = 8'h00;
    logic        d2_data_change = 1'b0;
    logic [15:0] d2_frame_data;
    logic        d2_frame_valid;
    logic        d2_phase_idx;
    logic        d2_overrun;
    logic        d2_overrun_clr = 1'b0;
    logic [7:0]  d2_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_commutator #(.DATA_WIDTH(8), .PHASES(4), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_change(data_change),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .phase_idx(phase_idx), .overrun(overrun),
`ifdef COMMUTATOR_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .overrun_clr(overrun_clr)
    );

`ifdef COMMUTATOR_DROP_CNT_EN
    poly_commutator #(.DATA_WIDTH(8), .PHASES(2), .CNT_WIDTH(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(d2_data_in), .data_change(d2_data_change),
        .frame_data(d2_frame_data), .frame_valid(d2_frame_valid), .frame_ready(1'b0),
        .phase_idx(d2_phase_idx), .overrun(d2_overrun), .drop_cnt(d2_drop_cnt),
        .overrun_clr(d2_overrun_clr)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        data_in     = d;
        data_change = 1'b1;
        tick();
        data_change = 1'b0;
    endtask

    initial begin
        // Reset applied before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_frame_data", 64'(frame_data), 64'h0);
        check("rst_frame_valid", 64'(frame_valid), 64'h0);
        check("rst_phase_idx", 64'(phase_idx), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
`ifdef COMMUTATOR_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // Basic frame, frame_ready high
        frame_ready = 1'b1;
        strobe(8'h80);
        check("basic_phase_after1", 64'(phase_idx), 64'h1);
        strobe(8'h81);
        strobe(8'h82);
        check("basic_valid_before", 64'(frame_valid), 64'h0);
        strobe(8'h83);
        check("basic_frame_data", 64'(frame_data), 64'h03020100);
        check("basic_frame_valid", 64'(frame_valid), 64'h1);
        check("basic_phase_wrap", 64'(phase_idx), 64'h0);
        tick();
        check("basic_valid_one_cycle", 64'(frame_valid), 64'h0);

        // Overrun: no ready, two frames
        frame_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(8'(i));
        check("ovr_first_frame", 64'(frame_data), 64'h83828180);
        check("ovr_first_valid", 64'(frame_valid), 64'h1);
        check("ovr_not_yet", 64'(overrun), 64'h0);
        for (int i = 4; i < 8; i++) strobe(8'(i));
        check("ovr_frame_kept", 64'(frame_data), 64'h83828180);
        check("ovr_flag", 64'(overrun), 64'h1);
        check("ovr_valid_kept", 64'(frame_valid), 64'h1);
`ifdef COMMUTATOR_DROP_CNT_EN
        check("ovr_drop_cnt", 64'(drop_cnt), 64'h1);
`endif
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'h0);
`ifdef COMMUTATOR_DROP_CNT_EN
        check("ovr_drop_cnt_cleared", 64'(drop_cnt), 64'h0);
`endif
        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 3; i++) strobe(8'h40);
        overrun_clr = 1'b1;
        strobe(8'h40);
        overrun_clr = 1'b0;
        check("ovr_set_wins", 64'(overrun), 64'h1);
        check("ovr_set_wins_data", 64'(frame_data), 64'h83828180);
`ifdef COMMUTATOR_DROP_CNT_EN
        check("ovr_cnt_clr_inc", 64'(drop_cnt), 64'h1);
`endif
        overrun_clr = 1'b1;
        frame_ready = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("drain_valid", 64'(frame_valid), 64'h0);
        check("drain_overrun", 64'(overrun), 64'h0);

        // Complete and accept in the same cycle
        frame_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
        check("sim_first_data", 64'(frame_data), 64'h93929190);
        for (int i = 0; i < 3; i++) strobe(8'h20 + 8'(i));
        frame_ready = 1'b1;
        strobe(8'h23);
        check("sim_new_data", 64'(frame_data), 64'hA3A2A1A0);
        check("sim_valid_stays", 64'(frame_valid), 64'h1);
        check("sim_no_overrun", 64'(overrun), 64'h0);
        tick();
        check("sim_accepted", 64'(frame_valid), 64'h0);

        // Back-to-back frames with ready tied high
        for (int i = 0; i < 8; i++) begin
            strobe(8'hF0 + 8'(i));
            check($sformatf("b2b_valid_%0d", i), 64'(frame_valid), (i == 3 || i == 7) ? 64'h1 : 64'h0);
        end
        check("b2b_second_data", 64'(frame_data), 64'h77767574);
        check("b2b_no_overrun", 64'(overrun), 64'h0);

        // Reset mid-frame
        strobe(8'h55);
        strobe(8'h66);
        check("mid_phase_before", 64'(phase_idx), 64'h2);
        rst = 1'b1;
        #1;
        check("mid_phase_async", 64'(phase_idx), 64'h0);
        check("mid_data_async", 64'(frame_data), 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
        check("mid_frame_data", 64'(frame_data), 64'h93929190);
        check("mid_frame_valid", 64'(frame_valid), 64'h1);

`ifdef COMMUTATOR_DROP_CNT_EN
        // Saturation on the two-phase instance
        for (int i = 0; i < 600; i++) begin
            d2_data_in     = 8'(i);
            d2_data_change = 1'b1;
            tick();
        end
        d2_data_change = 1'b0;
        check("sat_drop_cnt", 64'(d2_drop_cnt), 64'd255);
        check("sat_overrun", 64'(d2_overrun), 64'h1);
        check("sat_held_frame", 64'(d2_frame_data), 64'h8180);
        d2_data_change = 1'b1;
        tick();
        d2_overrun_clr = 1'b1;
        tick();
        d2_data_change = 1'b0;
        d2_overrun_clr = 1'b0;
        check("sat_clr_inc", 64'(d2_drop_cnt), 64'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
